// File: rtl/exec_pkg.sv
// Shared encodings for the execute issue stage: opselect codes, control-word
// field positions and the FSM state type.
package exec_pkg;

  localparam logic [2:0] OPS_SHIFT     = 3'b000;
  localparam logic [2:0] OPS_ARITH     = 3'b001;
  localparam logic [2:0] OPS_MEM_WRITE = 3'b100;
  localparam logic [2:0] OPS_MEM_READ  = 3'b101;

  // control_in layout: [6:4] operation, [3] imm_mode, [2:0] opselect
  localparam int CTL_OP_LO    = 4;
  localparam int CTL_IMM_MODE = 3;
  localparam int CTL_SEL_LO   = 0;

  // Shift amount comes from imm[6 +: SHAMT_W] unless imm[2] selects src2
  localparam int SHAMT_IMM_LO  = 6;
  localparam int SHAMT_SRC_BIT = 2;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } state_e;

endpackage

// File: rtl/execute_issue_stage_if.sv
// Handshake and data bus of the execute issue stage. The stage itself is the
// slave; the upstream/downstream/memory environment is the master.
interface execute_issue_stage_if #(
  parameter int DATA_W = 32
);
  localparam int SHAMT_W = $clog2(DATA_W);

  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  src1;
  logic [DATA_W-1:0]  src2;
  logic [DATA_W-1:0]  imm;
  logic [6:0]         control_in;
  logic               mem_rd_valid;
  logic [DATA_W-1:0]  mem_rd_data;
  logic [DATA_W-1:0]  mem_wr_data;
  logic               mem_wr_en;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  aluin1;
  logic [DATA_W-1:0]  aluin2;
  logic [2:0]         operation_out;
  logic [2:0]         opselect_out;
  logic [SHAMT_W-1:0] shift_number;
  logic               enable_arith;
  logic               enable_shift;
  logic               busy;

  modport slave (
    input  in_valid, src1, src2, imm, control_in, mem_rd_valid, mem_rd_data, out_ready,
    output in_ready, mem_wr_data, mem_wr_en, out_valid, aluin1, aluin2,
           operation_out, opselect_out, shift_number, enable_arith, enable_shift, busy
  );

  modport master (
    output in_valid, src1, src2, imm, control_in, mem_rd_valid, mem_rd_data, out_ready,
    input  in_ready, mem_wr_data, mem_wr_en, out_valid, aluin1, aluin2,
           operation_out, opselect_out, shift_number, enable_arith, enable_shift, busy
  );

endinterface

// File: rtl/exec_decode.sv
// Combinational decode of the control word plus selection of the candidate
// aluin2 and shift amount for a newly accepted instruction.
module exec_decode
  import exec_pkg::*;
#(
  parameter  int DATA_W  = 32,
  localparam int SHAMT_W = $clog2(DATA_W)
) (
  input  logic [6:0]         control_in,
  input  logic [DATA_W-1:0]  src2,
  input  logic [DATA_W-1:0]  imm,
  output logic [2:0]         operation,
  output logic [2:0]         opselect,
  output logic               imm_mode,
  output logic               is_arith,
  output logic               is_shift,
  output logic               is_mem_write,
  output logic               is_mem_read_wait,
  output logic [DATA_W-1:0]  aluin2_sel,
  output logic [SHAMT_W-1:0] shamt_sel
);

  assign operation = control_in[CTL_OP_LO +: 3];
  assign opselect  = control_in[CTL_SEL_LO +: 3];
  assign imm_mode  = control_in[CTL_IMM_MODE];

  assign is_arith         = (opselect == OPS_ARITH);
  assign is_shift         = (opselect == OPS_SHIFT);
  assign is_mem_write     = (opselect == OPS_MEM_WRITE);
  // Only immediate-mode loads actually wait on memory; others retire as NOPs
  assign is_mem_read_wait = (opselect == OPS_MEM_READ) && imm_mode;

  assign aluin2_sel = imm_mode ? imm : src2;
  assign shamt_sel  = imm[SHAMT_SRC_BIT] ? src2[SHAMT_W-1:0]
                                         : imm[SHAMT_IMM_LO +: SHAMT_W];

endmodule

// File: rtl/execute_issue_stage.sv
// Execute issue stage: accepts one instruction per cycle, registers the ALU
// operand bundle for downstream, and parks in WAIT_MEM for immediate loads
// until read data returns.
module execute_issue_stage
  import exec_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input logic             clock,
  input logic             reset,
  input logic             flush,
  execute_issue_stage_if.slave bus
);

  localparam int SHAMT_W = $clog2(DATA_W);

  state_e             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  aluin1_q, aluin1_d;
  logic [DATA_W-1:0]  aluin2_q, aluin2_d;
  logic [2:0]         operation_q, operation_d;
  logic [2:0]         opselect_q, opselect_d;
  logic [SHAMT_W-1:0] shift_number_q, shift_number_d;
  logic               enable_arith_q, enable_arith_d;
  logic               enable_shift_q, enable_shift_d;

  logic [2:0]         dec_operation, dec_opselect;
  logic               dec_imm_mode, dec_is_arith, dec_is_shift;
  logic               dec_is_mem_write, dec_is_mem_read_wait;
  logic [DATA_W-1:0]  dec_aluin2;
  logic [SHAMT_W-1:0] dec_shamt;

  logic in_ready, accept, mem_done;

  exec_decode #(.DATA_W(DATA_W)) u_decode (
    .control_in       (bus.control_in),
    .src2             (bus.src2),
    .imm              (bus.imm),
    .operation        (dec_operation),
    .opselect         (dec_opselect),
    .imm_mode         (dec_imm_mode),
    .is_arith         (dec_is_arith),
    .is_shift         (dec_is_shift),
    .is_mem_write     (dec_is_mem_write),
    .is_mem_read_wait (dec_is_mem_read_wait),
    .aluin2_sel       (dec_aluin2),
    .shamt_sel        (dec_shamt)
  );

  // A new bundle may load when the output slot is empty or draining this cycle
  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign mem_done = (state_q == ST_WAIT_MEM) && bus.mem_rd_valid;

  // Next-state and next-bundle selection; flush overrides accept and completion
  always_comb begin
    state_d        = state_q;
    out_valid_d    = out_valid_q;
    aluin1_d       = aluin1_q;
    aluin2_d       = aluin2_q;
    operation_d    = operation_q;
    opselect_d     = opselect_q;
    shift_number_d = shift_number_q;
    enable_arith_d = enable_arith_q;
    enable_shift_d = enable_shift_q;
    if (flush) begin
      state_d        = ST_IDLE;
      out_valid_d    = 1'b0;
      enable_arith_d = 1'b0;
      enable_shift_d = 1'b0;
    end else if (accept) begin
      aluin1_d       = bus.src1;
      operation_d    = dec_operation;
      opselect_d     = dec_opselect;
      out_valid_d    = 1'b1;
      enable_arith_d = 1'b0;
      enable_shift_d = 1'b0;
      shift_number_d = '0;
      if (dec_is_arith) begin
        aluin2_d       = dec_aluin2;
        enable_arith_d = 1'b1;
      end else if (dec_is_shift) begin
        shift_number_d = dec_shamt;
        enable_shift_d = 1'b1;
      end else if (dec_is_mem_read_wait) begin
        out_valid_d = 1'b0;
        state_d     = ST_WAIT_MEM;
      end
    end else if (mem_done) begin
      aluin2_d       = bus.mem_rd_data;
      enable_arith_d = 1'b1;
      enable_shift_d = 1'b0;
      shift_number_d = '0;
      out_valid_d    = 1'b1;
      state_d        = ST_IDLE;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d    = 1'b0;
      enable_arith_d = 1'b0;
      enable_shift_d = 1'b0;
    end
  end

  // State and bundle registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      out_valid_q    <= 1'b0;
      aluin1_q       <= '0;
      aluin2_q       <= '0;
      operation_q    <= '0;
      opselect_q     <= '0;
      shift_number_q <= '0;
      enable_arith_q <= 1'b0;
      enable_shift_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      out_valid_q    <= out_valid_d;
      aluin1_q       <= aluin1_d;
      aluin2_q       <= aluin2_d;
      operation_q    <= operation_d;
      opselect_q     <= opselect_d;
      shift_number_q <= shift_number_d;
      enable_arith_q <= enable_arith_d;
      enable_shift_q <= enable_shift_d;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.mem_wr_data   = bus.src2;
  assign bus.mem_wr_en     = accept && dec_is_mem_write && dec_imm_mode && !flush;
  assign bus.out_valid     = out_valid_q;
  assign bus.aluin1        = aluin1_q;
  assign bus.aluin2        = aluin2_q;
  assign bus.operation_out = operation_q;
  assign bus.opselect_out  = opselect_q;
  assign bus.shift_number  = shift_number_q;
  assign bus.enable_arith  = enable_arith_q;
  assign bus.enable_shift  = enable_shift_q;
  assign bus.busy          = (state_q == ST_WAIT_MEM);

endmodule

// File: tb/tb_execute_issue_stage.sv
// Bench for execute_issue_stage: directed scenarios followed by random traffic,
// all checked every cycle against a behavioural model of the stage.
module tb_execute_issue_stage;

  localparam int DW = 32;
  localparam int SW = $clog2(DW);

  logic clock = 1'b0;
  logic reset, flush;
  always #5 clock = ~clock;

  execute_issue_stage_if #(.DATA_W(DW)) bus();

  execute_issue_stage #(.DATA_W(DW)) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model: a pending-load flag plus the visible bundle
  bit          m_wait, m_ov, m_ea, m_es;
  logic [DW-1:0] m_a1, m_a2;
  logic [2:0]  m_op, m_os;
  logic [SW-1:0] m_sh;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_rdy();
    return !m_wait && (!m_ov || bus.out_ready);
  endfunction

  task automatic m_clear();
    m_wait = 0; m_ov = 0; m_ea = 0; m_es = 0;
    m_a1 = '0; m_a2 = '0; m_op = '0; m_os = '0; m_sh = '0;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".out_valid"},    bus.out_valid,     m_ov);
    chk({tag, ".aluin1"},       bus.aluin1,        m_a1);
    chk({tag, ".aluin2"},       bus.aluin2,        m_a2);
    chk({tag, ".operation"},    bus.operation_out, m_op);
    chk({tag, ".opselect"},     bus.opselect_out,  m_os);
    chk({tag, ".shift_number"}, bus.shift_number,  m_sh);
    chk({tag, ".enable_arith"}, bus.enable_arith,  m_ea);
    chk({tag, ".enable_shift"}, bus.enable_shift,  m_es);
    chk({tag, ".busy"},         bus.busy,          m_wait);
  endtask

  // One clock: check combinational outputs, advance the model, check registers
  task automatic cyc(input string tag);
    bit acc, im;
    logic [2:0] os;
    #1;
    acc = bus.in_valid && m_rdy();
    os  = bus.control_in[2:0];
    im  = bus.control_in[3];
    chk({tag, ".in_ready"},    bus.in_ready,    m_rdy());
    chk({tag, ".mem_wr_en"},   bus.mem_wr_en,   acc && os == 3'd4 && im && !flush);
    chk({tag, ".mem_wr_data"}, bus.mem_wr_data, bus.src2);
    if (reset) begin
      m_clear();
    end else if (flush) begin
      m_ov = 0; m_ea = 0; m_es = 0; m_wait = 0;
    end else if (acc) begin
      m_a1 = bus.src1; m_op = bus.control_in[6:4]; m_os = os;
      m_ov = 1; m_ea = 0; m_es = 0; m_sh = '0;
      if (os == 3'd1) begin
        m_a2 = im ? bus.imm : bus.src2;
        m_ea = 1;
      end else if (os == 3'd0) begin
        m_sh = bus.imm[2] ? SW'(bus.src2 % DW) : SW'((bus.imm >> 6) % DW);
        m_es = 1;
      end else if (os == 3'd5 && im) begin
        m_ov = 0; m_wait = 1;
      end
    end else if (m_wait && bus.mem_rd_valid) begin
      m_a2 = bus.mem_rd_data; m_ea = 1; m_es = 0; m_sh = '0; m_ov = 1; m_wait = 0;
    end else if (m_ov && bus.out_ready) begin
      m_ov = 0; m_ea = 0; m_es = 0;
    end
    @(posedge clock);
    #1;
    chk_regs(tag);
  endtask

  task automatic drive(input bit v, input logic [6:0] ctl, input logic [DW-1:0] s1,
                       input logic [DW-1:0] s2, input logic [DW-1:0] im,
                       input bit mrv, input logic [DW-1:0] md, input bit ordy);
    bus.in_valid = v; bus.control_in = ctl; bus.src1 = s1; bus.src2 = s2; bus.imm = im;
    bus.mem_rd_valid = mrv; bus.mem_rd_data = md; bus.out_ready = ordy;
  endtask

  localparam logic [6:0] C_ARITH_I = {3'd2, 1'b1, 3'b001};
  localparam logic [6:0] C_ARITH_R = {3'd6, 1'b0, 3'b001};
  localparam logic [6:0] C_LOAD    = {3'd3, 1'b1, 3'b101};
  localparam logic [6:0] C_SHIFT   = {3'd1, 1'b0, 3'b000};

  initial begin
    reset = 1; flush = 0;
    drive(0, '0, '0, '0, '0, 0, '0, 0);
    repeat (2) @(posedge clock);
    #1;
    m_clear();
    chk_regs("reset");
    reset = 0;

    // Immediate ARITH
    drive(1, C_ARITH_I, 32'h1111, 32'h2222, 32'h10, 0, '0, 1);
    cyc("arith_imm");
    chk("arith_imm.ov", bus.out_valid, 1);
    chk("arith_imm.a2", bus.aluin2, 32'h10);
    chk("arith_imm.ea", bus.enable_arith, 1);

    // Immediate load, data returns on the third waiting cycle
    drive(1, C_LOAD, 32'hA0, 32'h77, 32'h4, 0, '0, 1);
    cyc("load_acc");
    for (int i = 0; i < 3; i++) begin
      drive(1, C_ARITH_I, 32'h5, 32'h6, 32'h7, i == 2, 32'hDEADBEEF, 1);
      #1;
      chk("load_wait.busy", bus.busy, 1);
      chk("load_wait.in_ready", bus.in_ready, 0);
      cyc("load_wait");
    end
    chk("load_done.a2", bus.aluin2, 32'hDEADBEEF);
    chk("load_done.ov", bus.out_valid, 1);
    chk("load_done.busy", bus.busy, 0);

    // Shift from immediate field, then from src2
    drive(1, C_SHIFT, 32'h3, 32'hFFFF_FFF0, 32'd13 << 6, 0, '0, 1);
    cyc("shift_imm");
    chk("shift_imm.sh", bus.shift_number, 13);
    chk("shift_imm.es", bus.enable_shift, 1);
    drive(1, C_SHIFT, 32'h3, 32'h1F, 32'h4, 0, '0, 1);
    cyc("shift_reg");
    chk("shift_reg.sh", bus.shift_number, 31);
    chk("shift_reg.es", bus.enable_shift, 1);

    // Downstream stall for 4 cycles, then release and back-to-back issue
    drive(1, C_ARITH_R, 32'h9, 32'h55, 32'h0, 0, '0, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stall.in_ready", bus.in_ready, 0);
      cyc("stall");
    end
    chk("stall.sh_hold", bus.shift_number, 31);
    bus.out_ready = 1;
    cyc("release");
    chk("release.a2", bus.aluin2, 32'h55);
    chk("release.ea", bus.enable_arith, 1);
    drive(1, C_ARITH_R, 32'hA, 32'h66, 32'h0, 0, '0, 1);
    cyc("b2b");
    chk("b2b.a2", bus.aluin2, 32'h66);
    chk("b2b.ov", bus.out_valid, 1);

    // Store strobe
    drive(1, {3'd0, 1'b1, 3'b100}, 32'h1, 32'hCAFE, 32'h0, 0, '0, 1);
    #1;
    chk("store.wr_en", bus.mem_wr_en, 1);
    cyc("store");
    chk("store.ea", bus.enable_arith, 0);

    // Flush coinciding with load completion
    drive(1, C_LOAD, 32'hB0, 32'h0, 32'h0, 0, '0, 1);
    cyc("fl_load");
    drive(0, '0, '0, '0, '0, 1, 32'h1234, 1);
    flush = 1;
    cyc("fl_done");
    flush = 0;
    chk("fl_done.ov", bus.out_valid, 0);
    chk("fl_done.busy", bus.busy, 0);
    cyc("fl_stray");
    chk("fl_stray.a2", bus.aluin2, 32'h66);

    // Reset while waiting abandons the load
    drive(1, C_LOAD, 32'hC0, 32'h0, 32'h0, 0, '0, 1);
    cyc("rst_load");
    drive(0, '0, '0, '0, '0, 0, '0, 1);
    reset = 1;
    cyc("rst_wait");
    reset = 0;
    drive(0, '0, '0, '0, '0, 1, 32'hBEEF, 1);
    cyc("rst_stray");
    chk("rst_stray.ov", bus.out_valid, 0);
    chk("rst_stray.a2", bus.aluin2, 0);
    chk("rst_stray.a1", bus.aluin1, 0);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      logic [2:0] sel;
      case ($urandom_range(0, 4))
        0: sel = 3'b000;
        1: sel = 3'b001;
        2: sel = 3'b100;
        3: sel = 3'b101;
        default: sel = 3'($urandom);
      endcase
      drive(1'($urandom_range(0, 3) != 0), {3'($urandom), 1'($urandom), sel},
            $urandom, $urandom, $urandom, 1'($urandom_range(0, 2) == 0), $urandom,
            1'($urandom_range(0, 3) != 0));
      flush = ($urandom_range(0, 19) == 0);
      reset = ($urandom_range(0, 99) == 0);
      cyc("rand");
    end
    flush = 0; reset = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_issue_stage.md
EXECUTE_ISSUE_STAGE -- requirements
Module: execute_issue_stage

Interface
REQ-001 Parameter DATA_W, default 32, operand/data width; legal values are powers of two, 16 to 64.
REQ-002 Parameter SHAMT_W, default $clog2(DATA_W), shift-amount width; not overridable.
REQ-003 clock  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  synchronous pipeline flush, active-high.
REQ-006 in_valid  input  1  upstream instruction valid.
REQ-007 in_ready  output  1  stage can accept an instruction this cycle.
REQ-008 src1, src2  input  DATA_W each  register operands.
REQ-009 imm  input  DATA_W  sign-extended immediate.
REQ-010 control_in  input  7  control word: [6:4] operation, [3] imm_mode, [2:0] opselect.
REQ-011 mem_rd_valid  input  1  memory read data valid.
REQ-012 mem_rd_data  input  DATA_W  memory read data.
REQ-013 mem_wr_data  output  DATA_W  store data; equals src2 combinationally.
REQ-014 mem_wr_en  output  1  store strobe.
REQ-015 out_valid  input/output: output, 1 bit; downstream bundle valid.
REQ-016 out_ready  input  1  downstream can accept the bundle.
REQ-017 aluin1, aluin2  output  DATA_W each  registered ALU operands.
REQ-018 operation_out, opselect_out  output  3 each  registered control fields.
REQ-019 shift_number  output  SHAMT_W  registered shift amount.
REQ-020 enable_arith, enable_shift  output  1 each  registered unit enables.
REQ-021 busy  output  1  high while state is WAIT_MEM.

Function
REQ-022 opselect encodings SHALL be: SHIFT 3'b000, ARITH 3'b001, MEM_WRITE 3'b100, MEM_READ 3'b101; all others are NOP.
REQ-023 The FSM SHALL have two states: IDLE and WAIT_MEM.
REQ-024 in_ready SHALL be (state==IDLE) && (!out_valid || out_ready); accept = in_valid && in_ready.
REQ-025 mem_wr_en SHALL be the combinational product accept && opselect==MEM_WRITE && imm_mode.
REQ-026 On accept, aluin1, operation_out and opselect_out SHALL load src1, operation and opselect.
REQ-027 Accept with ARITH SHALL load aluin2=(imm_mode ? imm : src2), set enable_arith=1 and out_valid=1 at the next edge.
REQ-028 Accept with SHIFT SHALL load shift_number=(imm[2] ? src2[SHAMT_W-1:0] : imm[6+SHAMT_W-1:6]), set enable_shift=1 and out_valid=1.
REQ-029 Accept with MEM_READ and imm_mode=1 SHALL enter WAIT_MEM with out_valid=0.
REQ-030 In WAIT_MEM, the first cycle with mem_rd_valid=1 SHALL load aluin2=mem_rd_data, set enable_arith=1 and out_valid=1, and return to IDLE.
REQ-031 Accept of any other instruction (MEM_READ with imm_mode=0, MEM_WRITE, NOP) SHALL produce out_valid=1 with both enables 0, aluin2 held, and shift_number 0.
REQ-032 Whenever a bundle is loaded without a shift, shift_number SHALL be 0.
REQ-033 Whenever a bundle is loaded without an arith operation, enable_arith SHALL be 0.
REQ-034 While out_valid && !out_ready, all registered outputs SHALL hold their values (no bundle loss).
REQ-035 When out_valid && out_ready with no accept and no memory completion, out_valid SHALL clear and enables SHALL clear; data outputs hold.
REQ-036 Downstream handoff and a new accept in the same cycle SHALL load the new bundle with no bubble (back-to-back throughput 1/cycle).
REQ-037 mem_rd_valid outside WAIT_MEM SHALL be ignored.
REQ-038 flush SHALL clear out_valid, enable_arith and enable_shift, and force IDLE; it overrides accept and memory completion in the same cycle.
REQ-039 mem_wr_en SHALL be 0 during any cycle with flush=1.

Reset
REQ-040 reset SHALL have priority over flush.
REQ-041 reset SHALL force state=IDLE.
REQ-042 reset SHALL force out_valid, aluin1, aluin2, operation_out, opselect_out, shift_number, enable_arith and enable_shift to 0.
REQ-043 reset asserted during WAIT_MEM SHALL abandon the pending read; a later mem_rd_valid SHALL have no effect.

Structure
REQ-044 Package exec_pkg SHALL hold the opselect constants, control-field bit positions and the state enum.
REQ-045 One combinational sub-module, exec_decode, SHALL decode control_in and select the next aluin2 and shift_number values.

Verification
REQ-046 Reset, then ARITH with imm_mode=1, imm=32'h10, out_ready=1 -> next cycle: out_valid=1, aluin2=32'h10, enable_arith=1.
REQ-047 MEM_READ with imm_mode=1; mem_rd_valid pulses 3 cycles later with data 32'hDEADBEEF -> busy=1 for 3 cycles, in_ready=0, then aluin2=32'hDEADBEEF, out_valid=1.
REQ-048 SHIFT with imm[2]=0, imm[10:6]=5'd13, followed by imm[2]=1, src2=32'h1F -> shift_number=13, then 31, enable_shift=1 both times.
REQ-049 out_ready=0 for 4 cycles with in_valid=1 -> in_ready=0 and outputs stable; on out_ready=1, next bundle follows immediately.
REQ-050 flush in the cycle mem_rd_valid arrives in WAIT_MEM -> out_valid=0 and IDLE; reset in WAIT_MEM -> all outputs 0.
